ej32_cpu: RTL and testbench



---
 rtl/ej32_pkg.sv | 60 ++++++
 rtl/ej32_stack.sv | 33 +++
 rtl/ej32_cpu.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_ej32_cpu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// ej32_pkg: shared definitions for the eJ32 stack CPU core.
//   - Width macros U8 / U32 / IU used for byte, word and interpreter-unit values.
//   - Default memory width and stack depths.
//   - opcode_t: the JVM byte encodings the core understands.
//   - Sign-extension helpers used by the immediate and load paths.
`ifndef EJ32_PKG_SV
`define EJ32_PKG_SV

`define U8  logic [7:0]
`define U32 logic [31:0]
`define IU  logic [31:0]

package ej32_pkg;

    localparam int ASZ_DEF = 17;   // memory address width
    localparam int DSZ_DEF = 64;   // data-stack depth
    localparam int RSZ_DEF = 32;   // return-stack depth

    typedef enum logic [7:0] {
        op_nop           = 8'h00,
        op_iconst_m1     = 8'h02,
        op_iconst_0      = 8'h03,
        op_iconst_1      = 8'h04,
        op_iconst_2      = 8'h05,
        op_iconst_3      = 8'h06,
        op_iconst_4      = 8'h07,
        op_iconst_5      = 8'h08,
        op_bipush        = 8'h10,
        op_sipush        = 8'h11,
        op_iaload        = 8'h2E,
        op_iastore       = 8'h4F,
        op_pop           = 8'h57,
        op_dup           = 8'h59,
        op_swap          = 8'h5F,
        op_iadd          = 8'h60,
        op_isub          = 8'h64,
        op_ineg          = 8'h74,
        op_iand          = 8'h7E,
        op_ior           = 8'h80,
        op_ixor          = 8'h82,
        op_ifeq          = 8'h99,
        op_goto          = 8'hA7,
        op_return        = 8'hB1,
        op_invokevirtual = 8'hB6,
        op_err           = 8'hFF
    } opcode_t;

    // Sign-extend a byte to a 32-bit stack word.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Sign-extend a halfword to a 32-bit stack word.
    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

`endif

// File: rtl/ej32_stack.sv
// ej32_stack: LIFO storage RAM with one synchronous write port and one
// combinational read port. The pointer arithmetic lives in the CPU; this
// block only stores words. Contents are not reset.
//   clk    in  : clock, rising edge
//   i_we   in  : write enable
//   i_wa   in  : write address
//   i_wd   in  : write data
//   i_ra   in  : read address
//   o_rd   out : mem[i_ra], combinational
module ej32_stack #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wa,
    input  logic [WIDTH-1:0]         i_wd,
    input  logic [$clog2(DEPTH)-1:0] i_ra,
    output logic [WIDTH-1:0]         o_rd
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single write port; storage has no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/ej32_cpu.sv
// ej32_cpu: single-clock eJ32 stack CPU executing a JVM-bytecode subset.
// The core reads one byte per cycle from a synchronous byte memory: the
// address driven on mem_a_o is sampled at the edge and the byte appears on
// mem_d_i during the following cycle. In phase 0 mem_d_i is always the
// opcode at p; multi-phase instructions keep p at the opcode address until
// their final phase and latch the opcode into code.
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   mem_a_o   out : next memory address (combinational)
//   mem_d_i   in  : memory byte read at the previous edge
//   mem_d_o   out : write byte
//   mem_we_o  out : write strobe, paired with mem_a_o
//   p_o       out : program counter
//   code_o    out : latched opcode
//   phase_o   out : instruction phase
//   t_o, s_o  out : top and next-on-stack
//   sp_o      out : data-stack pointer
//   rp_o      out : return-stack pointer
//   r_o       out : top of return stack
module ej32_cpu
    import ej32_pkg::*;
#(
    parameter int ASZ = ASZ_DEF,
    parameter int DSZ = DSZ_DEF,
    parameter int RSZ = RSZ_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ASZ-1:0]         mem_a_o,
    input  logic [7:0]             mem_d_i,
    output logic [7:0]             mem_d_o,
    output logic                   mem_we_o,
    output logic [ASZ-1:0]         p_o,
    output logic [7:0]             code_o,
    output logic [2:0]             phase_o,
    output logic [31:0]            t_o,
    output logic [31:0]            s_o,
    output logic [$clog2(DSZ)-1:0] sp_o,
    output logic [$clog2(RSZ)-1:0] rp_o,
    output logic [ASZ-1:0]         r_o
);

    localparam int SPW = $clog2(DSZ);
    localparam int RPW = $clog2(RSZ);

    localparam logic [ASZ-1:0] P_ONE   = ASZ'(2'd1);
    localparam logic [ASZ-1:0] P_TWO   = ASZ'(2'd2);
    localparam logic [ASZ-1:0] P_THREE = ASZ'(2'd3);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1'b1);
    localparam logic [RPW-1:0] RP_ONE  = RPW'(1'b1);

    // Architectural state
    logic [ASZ-1:0] r_p;
    logic [2:0]     r_phase;
    `U8             r_code;
    `U32            r_t;
    logic [SPW-1:0] r_sp;
    logic [RPW-1:0] r_rp;
    logic [23:0]    r_n;        // immediate / load byte shifter

    // Next-state and datapath wires
    logic [ASZ-1:0] w_p_nxt;
    logic [2:0]     w_phase_nxt;
    logic [7:0]     w_code_nxt;
    logic [31:0]    w_t_nxt;
    logic [SPW-1:0] w_sp_nxt;
    logic [RPW-1:0] w_rp_nxt;
    logic [23:0]    w_n_nxt;
    logic [7:0]     w_op;
    logic [15:0]    w_imm16;
    logic [ASZ-1:0] w_ta;
    logic [ASZ-1:0] w_br;
    logic [ASZ-1:0] w_call;
    logic [ASZ-1:0] w_a;
    logic           w_we;
    logic [7:0]     w_dout;
    logic           w_ds_we;
    logic [SPW-1:0] w_ds_wa;
    logic [31:0]    w_ds_wd;
    `IU             w_s;
    logic           w_rs_we;
    logic [RPW-1:0] w_rs_wa;
    logic [ASZ-1:0] w_rs_wd;
    logic [ASZ-1:0] w_r;

    ej32_stack #(.DEPTH(DSZ), .WIDTH(32)) u_dstk (
        .clk  (clk),
        .i_we (w_ds_we & ~rst),
        .i_wa (w_ds_wa),
        .i_wd (w_ds_wd),
        .i_ra (r_sp),
        .o_rd (w_s)
    );

    ej32_stack #(.DEPTH(RSZ), .WIDTH(ASZ)) u_rstk (
        .clk  (clk),
        .i_we (w_rs_we & ~rst),
        .i_wa (w_rs_wa),
        .i_wd (w_rs_wd),
        .i_ra (r_rp),
        .o_rd (w_r)
    );

    // Decode, phase sequencing, ALU and memory-address selection.
    always_comb begin
        // In phase 0 the opcode is still on the memory bus; later it is held.
        w_op        = (r_phase == 3'd0) ? mem_d_i : r_code;
        w_imm16     = {r_n[7:0], mem_d_i};
        w_ta        = r_t[ASZ-1:0] + ASZ'(r_phase);
        // Branch offsets are relative to the opcode address, which p still holds.
        w_br        = r_p + {{(ASZ-16){w_imm16[15]}}, w_imm16};
        w_call      = {{(ASZ-16){1'b0}}, w_imm16};
        w_p_nxt     = r_p;
        w_phase_nxt = 3'd0;
        w_code_nxt  = w_op;
        w_t_nxt     = r_t;
        w_sp_nxt    = r_sp;
        w_rp_nxt    = r_rp;
        w_n_nxt     = (r_phase == 3'd0) ? r_n : {r_n[15:0], mem_d_i};
        w_a         = r_p + P_ONE;
        w_we        = 1'b0;
        w_dout      = 8'h00;
        w_ds_we     = 1'b0;
        w_ds_wa     = r_sp + SP_ONE;
        w_ds_wd     = r_t;
        w_rs_we     = 1'b0;
        w_rs_wa     = r_rp + RP_ONE;
        w_rs_wd     = r_p + P_THREE;

        case (w_op)
            op_iconst_m1, op_iconst_0, op_iconst_1, op_iconst_2,
            op_iconst_3, op_iconst_4, op_iconst_5: begin
                w_p_nxt  = r_p + P_ONE;
                w_ds_we  = 1'b1;
                w_sp_nxt = r_sp + SP_ONE;
                w_t_nxt  = sext8(w_op - 8'd3);
            end
            op_dup: begin
                w_p_nxt  = r_p + P_ONE;
                w_ds_we  = 1'b1;
                w_sp_nxt = r_sp + SP_ONE;
            end
            op_pop: begin
                w_p_nxt  = r_p + P_ONE;
                w_t_nxt  = w_s;
                w_sp_nxt = r_sp - SP_ONE;
            end
            op_swap: begin
                w_p_nxt = r_p + P_ONE;
                w_ds_we = 1'b1;
                w_ds_wa = r_sp;
                w_t_nxt = w_s;
            end
            op_iadd, op_isub, op_iand, op_ior, op_ixor: begin
                w_p_nxt  = r_p + P_ONE;
                w_sp_nxt = r_sp - SP_ONE;
                case (w_op)
                    op_iadd: w_t_nxt = w_s + r_t;
                    op_isub: w_t_nxt = w_s - r_t;
                    op_iand: w_t_nxt = w_s & r_t;
                    op_ior:  w_t_nxt = w_s | r_t;
                    op_ixor: w_t_nxt = w_s ^ r_t;
                    default: w_t_nxt = r_t;
                endcase
            end
            op_ineg: begin
                w_p_nxt = r_p + P_ONE;
                w_t_nxt = 32'd0 - r_t;
            end
            op_bipush: begin
                case (r_phase)
                    3'd0: w_phase_nxt = 3'd1;
                    3'd1: begin
                        w_p_nxt  = r_p + P_TWO;
                        w_a      = r_p + P_TWO;
                        w_ds_we  = 1'b1;
                        w_sp_nxt = r_sp + SP_ONE;
                        w_t_nxt  = sext8(mem_d_i);
                    end
                    default: w_phase_nxt = 3'd0;
                endcase
            end
            op_sipush, op_goto, op_ifeq, op_invokevirtual: begin
                case (r_phase)
                    3'd0: w_phase_nxt = 3'd1;
                    3'd1: begin
                        w_phase_nxt = 3'd2;
                        w_a         = r_p + P_TWO;
                    end
                    3'd2: begin
                        case (w_op)
                            op_sipush: begin
                                w_p_nxt  = r_p + P_THREE;
                                w_a      = r_p + P_THREE;
                                w_ds_we  = 1'b1;
                                w_sp_nxt = r_sp + SP_ONE;
                                w_t_nxt  = sext16(w_imm16);
                            end
                            op_goto: begin
                                w_p_nxt = w_br;
                                w_a     = w_br;
                            end
                            op_ifeq: begin
                                w_t_nxt  = w_s;
                                w_sp_nxt = r_sp - SP_ONE;
                                if (r_t == 32'd0) begin
                                    w_p_nxt = w_br;
                                    w_a     = w_br;
                                end else begin
                                    w_p_nxt = r_p + P_THREE;
                                    w_a     = r_p + P_THREE;
                                end
                            end
                            op_invokevirtual: begin
                                w_rs_we  = 1'b1;
                                w_rp_nxt = r_rp + RP_ONE;
                                w_p_nxt  = w_call;
                                w_a      = w_call;
                            end
                            default: begin
                                w_p_nxt = r_p + P_THREE;
                                w_a     = r_p + P_THREE;
                            end
                        endcase
                    end
                    default: w_phase_nxt = 3'd0;
                endcase
            end
            op_return: begin
                w_p_nxt  = w_r;
                w_a      = w_r;
                w_rp_nxt = r_rp - RP_ONE;
            end
            op_iaload: begin
                // Bytes arrive one cycle after their address; the shifter
                // gathers the first three, the fourth comes straight off the bus.
                case (r_phase)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        w_a         = w_ta;
                        w_phase_nxt = r_phase + 3'd1;
                    end
                    3'd4: begin
                        w_t_nxt = {r_n, mem_d_i};
                        w_p_nxt = r_p + P_ONE;
                    end
                    default: w_phase_nxt = 3'd0;
                endcase
            end
            op_iastore: begin
                case (r_phase)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        w_a         = w_ta;
                        w_we        = 1'b1;
                        w_phase_nxt = r_phase + 3'd1;
                        case (r_phase)
                            3'd0:    w_dout = w_s[31:24];
                            3'd1:    w_dout = w_s[23:16];
                            3'd2:    w_dout = w_s[15:8];
                            default: w_dout = w_s[7:0];
                        endcase
                        // Address is dropped after the last byte is sent.
                        if (r_phase == 3'd3) begin
                            w_t_nxt  = w_s;
                            w_sp_nxt = r_sp - SP_ONE;
                        end else begin
                            w_t_nxt  = r_t;
                            w_sp_nxt = r_sp;
                        end
                    end
                    3'd4: begin
                        w_t_nxt  = w_s;
                        w_sp_nxt = r_sp - SP_ONE;
                        w_p_nxt  = r_p + P_ONE;
                    end
                    default: w_phase_nxt = 3'd0;
                endcase
            end
            default: begin
                // nop and every unimplemented opcode
                w_p_nxt = r_p + P_ONE;
            end
        endcase
    end

    // Architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= {ASZ{1'b0}};
            r_phase <= 3'd0;
            r_code  <= 8'h00;
            r_t     <= 32'd0;
            r_sp    <= {SPW{1'b0}};
            r_rp    <= {RPW{1'b0}};
            r_n     <= 24'd0;
        end else begin
            r_p     <= w_p_nxt;
            r_phase <= w_phase_nxt;
            r_code  <= w_code_nxt;
            r_t     <= w_t_nxt;
            r_sp    <= w_sp_nxt;
            r_rp    <= w_rp_nxt;
            r_n     <= w_n_nxt;
        end
    end

    // Reset forces address 0 so the memory presents opcode 0 on release.
    assign mem_a_o  = rst ? {ASZ{1'b0}} : w_a;
    assign mem_we_o = w_we & ~rst;
    assign mem_d_o  = rst ? 8'h00 : w_dout;

    assign p_o     = r_p;
    assign code_o  = r_code;
    assign phase_o = r_phase;
    assign t_o     = r_t;
    assign s_o     = w_s;
    assign sp_o    = r_sp;
    assign rp_o    = r_rp;
    assign r_o     = w_r;

endmodule

// File: tb/tb_ej32_cpu.sv
// tb_ej32_cpu: scoreboard bench for ej32_cpu. Programs are loaded into a
// behavioural byte memory while reset is held. For each program the
// expected architectural state after instruction k is queued; the monitor
// counts instruction boundaries (phase 0 outside reset, event 0 being the
// reset state) and pops/compares every expectation tagged with that count.
module tb_ej32_cpu;

    localparam int ASZ = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ASZ-1:0]   mem_a_o;
    logic [7:0]       mem_d_i;
    logic [7:0]       mem_d_o;
    logic             mem_we_o;
    logic [ASZ-1:0]   p_o;
    logic [7:0]       code_o;
    logic [2:0]       phase_o;
    logic [31:0]      t_o;
    logic [31:0]      s_o;
    logic [5:0]       sp_o;
    logic [4:0]       rp_o;
    logic [ASZ-1:0]   r_o;

    logic             ld_we = 1'b0;
    logic [ASZ-1:0]   ld_a  = '0;
    logic [7:0]       ld_d  = 8'h00;
    logic [7:0]       mem [0:(1<<ASZ)-1];
    logic [7:0]       pb [$];

    typedef enum int {K_P, K_T, K_S, K_SP, K_RP, K_R, K_C, K_MEM} kind_t;
    typedef struct {
        int          n;
        kind_t       k;
        int          a;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   ev     = 0;

    ej32_cpu dut (
        .clk      (clk),
        .rst      (rst),
        .mem_a_o  (mem_a_o),
        .mem_d_i  (mem_d_i),
        .mem_d_o  (mem_d_o),
        .mem_we_o (mem_we_o),
        .p_o      (p_o),
        .code_o   (code_o),
        .phase_o  (phase_o),
        .t_o      (t_o),
        .s_o      (s_o),
        .sp_o     (sp_o),
        .rp_o     (rp_o),
        .r_o      (r_o)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory; bench loader has priority over CPU writes.
    always @(posedge clk) begin
        if (ld_we) mem[ld_a] <= ld_d;
        else if (mem_we_o) mem[mem_a_o] <= mem_d_o;
        mem_d_i <= mem[mem_a_o];
    end

    // Monitor: compare queued expectations at each instruction boundary.
    initial begin
        forever begin
            exp_t        e;
            logic [31:0] act;
            @(negedge clk);
            if (rst) begin
                ev = 0;
            end else if (phase_o == 3'd0) begin
                while (sb.size() > 0 && sb[0].n == ev) begin
                    e = sb.pop_front();
                    case (e.k)
                        K_P:     act = 32'(p_o);
                        K_T:     act = t_o;
                        K_S:     act = s_o;
                        K_SP:    act = 32'(sp_o);
                        K_RP:    act = 32'(rp_o);
                        K_R:     act = 32'(r_o);
                        K_C:     act = 32'(code_o);
                        default: act = 32'(mem[e.a]);
                    endcase
                    checks++;
                    if (act !== e.v) begin
                        errors++;
                        $display("FAIL %s (after instr %0d): got %08h expected %08h",
                                 e.nm, ev, act, e.v);
                    end
                end
                ev++;
            end
        end
    end

    task automatic ld(input int base);
        for (int i = 0; i < pb.size(); i++) begin
            ld_we = 1'b1;
            ld_a  = ASZ'(base + i);
            ld_d  = pb[i];
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0;
    endtask

    task automatic ex(input int n, input kind_t k, input logic [31:0] v, input string nm);
        sb.push_back('{n, k, 0, v, nm});
    endtask

    task automatic exm(input int n, input int a, input logic [31:0] v, input string nm);
        sb.push_back('{n, K_MEM, a, v, nm});
    endtask

    task automatic run(input string nm);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 400 && sb.size() > 0; c++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d expectations pending, required 0", nm, sb.size());
            sb.delete();
        end
        #1 rst = 1'b1;
    endtask

    initial begin
        // iconst_2 iconst_3 iadd, plus reset state
        pb = '{8'h05, 8'h06, 8'h60, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(0, K_P, 32'h0, "rst p");    ex(0, K_SP, 32'h0, "rst sp");
        ex(0, K_RP, 32'h0, "rst rp");  ex(0, K_T, 32'h0, "rst T");
        ex(0, K_C, 32'h0, "rst code");
        ex(1, K_T, 32'h2, "ic2 T");    ex(1, K_SP, 32'h1, "ic2 sp");  ex(1, K_P, 32'h1, "ic2 p");
        ex(2, K_T, 32'h3, "ic3 T");    ex(2, K_S, 32'h2, "ic3 S");    ex(2, K_SP, 32'h2, "ic3 sp");
        ex(3, K_T, 32'h5, "iadd T");   ex(3, K_SP, 32'h1, "iadd sp"); ex(3, K_P, 32'h3, "iadd p");
        run("arith");

        // bipush FF; sipush 12 34
        pb = '{8'h10, 8'hFF, 8'h11, 8'h12, 8'h34, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(1, K_T, 32'hFFFFFFFF, "bipush T"); ex(1, K_P, 32'h2, "bipush p"); ex(1, K_SP, 32'h1, "bipush sp");
        ex(2, K_T, 32'h00001234, "sipush T"); ex(2, K_S, 32'hFFFFFFFF, "sipush S");
        ex(2, K_P, 32'h5, "sipush p");        ex(2, K_SP, 32'h2, "sipush sp");
        run("imm");

        // goto 0x10; invokevirtual 0x100; iconst_1; return
        pb = '{8'hA7, 8'h00, 8'h10}; ld(0);
        pb = '{8'hB6, 8'h01, 8'h00, 8'hA7, 8'h00, 8'h00}; ld(16'h10);
        pb = '{8'h04, 8'hB1}; ld(16'h100);
        ex(1, K_P, 32'h10, "goto p");
        ex(2, K_RP, 32'h1, "call rp"); ex(2, K_R, 32'h13, "call r"); ex(2, K_P, 32'h100, "call p");
        ex(3, K_T, 32'h1, "sub T");    ex(3, K_SP, 32'h1, "sub sp");
        ex(4, K_P, 32'h13, "ret p");   ex(4, K_RP, 32'h0, "ret rp"); ex(4, K_T, 32'h1, "ret T");
        run("call");

        // iaload word at 0x200, iastore to 0x1400, iaload back
        pb = '{8'h11, 8'h22, 8'h33, 8'h44}; ld(16'h200);
        pb = '{8'hAA, 8'hAA, 8'hAA, 8'hAA}; ld(16'h1400);
        pb = '{8'h11, 8'h02, 8'h00, 8'h2E, 8'h11, 8'h14, 8'h00, 8'h4F,
               8'h11, 8'h14, 8'h00, 8'h2E, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(1, K_T, 32'h200, "sip200 T");     ex(1, K_SP, 32'h1, "sip200 sp");
        ex(2, K_T, 32'h11223344, "iaload T"); ex(2, K_P, 32'h4, "iaload p");
        ex(3, K_T, 32'h1400, "sip1400 T");   ex(3, K_S, 32'h11223344, "sip1400 S");
        ex(4, K_SP, 32'h0, "iastore sp");    ex(4, K_P, 32'h8, "iastore p"); ex(4, K_T, 32'h0, "iastore T");
        exm(4, 32'h1400, 32'h11, "st b0");   exm(4, 32'h1401, 32'h22, "st b1");
        exm(4, 32'h1402, 32'h33, "st b2");   exm(4, 32'h1403, 32'h44, "st b3");
        ex(6, K_T, 32'h11223344, "reload T"); ex(6, K_P, 32'hC, "reload p"); ex(6, K_SP, 32'h1, "reload sp");
        run("mem");

        // stack/ALU mix
        pb = '{8'h08, 8'h07, 8'h64, 8'h59, 8'h74, 8'h5F, 8'h60, 8'h10, 8'h0F, 8'h10, 8'h3C,
               8'h7E, 8'h10, 8'h30, 8'h80, 8'h02, 8'h82, 8'h57, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(3, K_T, 32'h1, "isub T");          ex(3, K_SP, 32'h1, "isub sp");
        ex(4, K_T, 32'h1, "dup T");           ex(4, K_S, 32'h1, "dup S");   ex(4, K_SP, 32'h2, "dup sp");
        ex(5, K_T, 32'hFFFFFFFF, "ineg T");
        ex(6, K_T, 32'h1, "swap T");          ex(6, K_S, 32'hFFFFFFFF, "swap S");
        ex(7, K_T, 32'h0, "iadd wrap T");     ex(7, K_SP, 32'h1, "iadd wrap sp");
        ex(10, K_T, 32'h0C, "iand T");
        ex(12, K_T, 32'h3C, "ior T");
        ex(14, K_T, 32'hFFFFFFC3, "ixor T");  ex(14, K_SP, 32'h2, "ixor sp");
        ex(15, K_T, 32'h0, "pop T");          ex(15, K_SP, 32'h1, "pop sp");
        run("alu");

        // iconst_0; ifeq +5 taken
        pb = '{8'h03, 8'h99, 8'h00, 8'h05, 8'h00, 8'h00, 8'h07, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(2, K_P, 32'h6, "ifeq tk p"); ex(2, K_SP, 32'h0, "ifeq tk sp");
        ex(3, K_T, 32'h4, "ifeq tk T"); ex(3, K_P, 32'h7, "ifeq tk p2");
        run("ifeq_taken");

        // iconst_1; ifeq falls through
        pb = '{8'h04, 8'h99, 8'h00, 8'h05, 8'h08, 8'hA7, 8'h00, 8'h00}; ld(0);
        ex(2, K_P, 32'h4, "ifeq nt p"); ex(2, K_SP, 32'h0, "ifeq nt sp");
        ex(3, K_T, 32'h5, "ifeq nt T"); ex(3, K_P, 32'h5, "ifeq nt p2");
        run("ifeq_fall");

        // unknown opcode CA as nop; goto -3 loops back to 0
        pb = '{8'hCA, 8'h00, 8'h00, 8'hA7, 8'hFF, 8'hFD}; ld(0);
        ex(1, K_P, 32'h1, "unk p");  ex(1, K_T, 32'h0, "unk T"); ex(1, K_SP, 32'h0, "unk sp");
        ex(4, K_P, 32'h0, "loop p"); ex(5, K_P, 32'h1, "loop p2");
        run("goto_loop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
